// File: rtl/eco32_core_jcr_pkg.sv
// Shared JCR geometry, half-enable encodings and the write-request FIFO entry.
package eco32_core_jcr_pkg;

  localparam int unsigned JCR_TID_W   = 1;
  localparam int unsigned JCR_ADDR_W  = 4;
  localparam int unsigned JCR_ENTRIES = 32;
  localparam int unsigned JCR_DATA_W  = 32;

  localparam logic [1:0] JCR_BE_L = 2'b01;
  localparam logic [1:0] JCR_BE_H = 2'b10;

  // One buffered JCR update: 1 + 4 + 2 + 32 + 32 = 71 bits
  typedef struct packed {
    logic [JCR_TID_W-1:0]  tid;
    logic [JCR_ADDR_W-1:0] addr;
    logic [1:0]            be;
    logic [JCR_DATA_W-1:0] data_l;
    logic [JCR_DATA_W-1:0] data_h;
  } jcr_req_t;

endpackage

// File: rtl/eco32_core_jcr_fifo.sv
// Synchronous request FIFO with occupancy output; storage is left unreset
// so it maps onto distributed RAM. DEPTH must be a power of two.
module eco32_core_jcr_fifo
  import eco32_core_jcr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned LW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  jcr_req_t      push_data,
  input  logic          pop,
  output jcr_req_t      pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  jcr_req_t      mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Level can only reach DEPTH by setting its top bit
  assign full     = level[PW];
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally modulo DEPTH; level tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/eco32_core_jcr_wr.sv
// JCR write-side sequencer: buffers update requests and issues one registered
// write beat per cycle to the jump unit's JCR RAMs. Defining ECO32_JCR_INIT_EN
// adds a post-reset sweep that writes every entry with INIT_DATAL/INIT_DATAH.
module eco32_core_jcr_wr
  import eco32_core_jcr_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] INIT_DATAL = 32'd0,
  parameter logic [31:0] INIT_DATAH = 32'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_stb,
  output logic                     req_rdy,
  input  logic                     req_tid,
  input  logic [3:0]               req_addr,
  input  logic [1:0]               req_be,
  input  logic [31:0]              req_dataL,
  input  logic [31:0]              req_dataH,
  output logic [1:0]               jcr_wen,
  output logic                     jcr_tid,
  output logic [3:0]               jcr_addr,
  output logic [31:0]              jcr_dataL,
  output logic [31:0]              jcr_dataH,
  output logic                     o_init_done,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_level
);

  jcr_req_t push_data;
  jcr_req_t head;
  logic     full;
  logic     empty;
  logic     push;
  logic     pop;
  logic     load;

  assign push_data = '{tid: req_tid, addr: req_addr, be: req_be,
                       data_l: req_dataL, data_h: req_dataH};

  // Ready comes from registered occupancy only, never from the same-cycle pop
  assign req_rdy = !rst && o_init_done && !full;
  assign push    = req_stb && req_rdy;
  assign pop     = o_init_done && !empty;
  // A be=00 beat still consumes a slot but leaves address/data untouched
  assign load    = pop && (head.be != 2'b00);
  assign o_busy  = (o_level != '0) || (jcr_wen != 2'b00);

  eco32_core_jcr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (o_level)
  );

`ifdef ECO32_JCR_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t     state;
  logic [4:0] sweep;
  logic       init_done;

  assign o_init_done = init_done;

  // Init sweep over all entries, then one FIFO entry per write beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep     <= '0;
      init_done <= 1'b0;
      jcr_wen   <= '0;
      jcr_tid   <= '0;
      jcr_addr  <= '0;
      jcr_dataL <= '0;
      jcr_dataH <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          jcr_wen               <= JCR_BE_L | JCR_BE_H;
          {jcr_tid, jcr_addr}   <= sweep;
          jcr_dataL             <= INIT_DATAL;
          jcr_dataH             <= INIT_DATAH;
          sweep                 <= sweep + 5'd1;
          if (sweep == 5'(JCR_ENTRIES - 1)) state <= ST_RUN;
        end
        default: begin
          init_done <= 1'b1;
          jcr_wen   <= pop ? head.be : 2'b00;
          if (load) begin
            jcr_tid   <= head.tid;
            jcr_addr  <= head.addr;
            jcr_dataL <= head.data_l;
            jcr_dataH <= head.data_h;
          end
        end
      endcase
    end
  end
`else
  logic unused_init;

  assign o_init_done = 1'b1;
  // Sweep values have no effect without the sweep
  assign unused_init = ^{INIT_DATAL, INIT_DATAH};

  // One FIFO entry per write beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jcr_wen   <= '0;
      jcr_tid   <= '0;
      jcr_addr  <= '0;
      jcr_dataL <= '0;
      jcr_dataH <= '0;
    end else begin
      jcr_wen <= pop ? head.be : 2'b00;
      if (load) begin
        jcr_tid   <= head.tid;
        jcr_addr  <= head.addr;
        jcr_dataL <= head.data_l;
        jcr_dataH <= head.data_h;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eco32_core_jcr_wr.sv
// Bench for eco32_core_jcr_wr: directed scenarios plus random traffic checked
// against a queue model of accepted requests and their expected issue edges.
module tb_eco32_core_jcr_wr;
  import eco32_core_jcr_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LW      = $clog2(DEPTH) + 1;
  localparam logic [31:0] INIT_DL = 32'hA5A5_0F0F;
  localparam logic [31:0] INIT_DH = 32'h5A5A_F0F0;
`ifdef ECO32_JCR_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_stb = 1'b0;
  logic          req_rdy;
  logic          req_tid = 1'b0;
  logic [3:0]    req_addr = '0;
  logic [1:0]    req_be = '0;
  logic [31:0]   req_dataL = '0;
  logic [31:0]   req_dataH = '0;
  logic [1:0]    jcr_wen;
  logic          jcr_tid;
  logic [3:0]    jcr_addr;
  logic [31:0]   jcr_dataL;
  logic [31:0]   jcr_dataH;
  logic          o_init_done;
  logic          o_busy;
  logic [LW-1:0] o_level;

  int total = 0;
  int bad   = 0;

  eco32_core_jcr_wr #(.DEPTH(DEPTH), .INIT_DATAL(INIT_DL), .INIT_DATAH(INIT_DH)) dut (
    .clk(clk), .rst(rst), .req_stb(req_stb), .req_rdy(req_rdy), .req_tid(req_tid),
    .req_addr(req_addr), .req_be(req_be), .req_dataL(req_dataL), .req_dataH(req_dataH),
    .jcr_wen(jcr_wen), .jcr_tid(jcr_tid), .jcr_addr(jcr_addr), .jcr_dataL(jcr_dataL),
    .jcr_dataH(jcr_dataH), .o_init_done(o_init_done), .o_busy(o_busy), .o_level(o_level)
  );

  always #5 clk = ~clk;

  // Reference model: each accepted request is issued at edge max(accept+1, previous issue+1)
  typedef struct {
    int unsigned issue;
    logic        tid;
    logic [3:0]  addr;
    logic [1:0]  be;
    logic [31:0] dl;
    logic [31:0] dh;
  } exp_t;

  exp_t        q[$];
  int unsigned edges = 0;
  int unsigned last_issue = 0;
  int unsigned beats_seen = 0;
  bit          mon_en = 1'b0;
  exp_t        m_e;
  bit          m_beat;
  int unsigned m_iss;

  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      q.delete();
      last_issue = 0;
    end else begin
      m_beat = 1'b0;
      if (q.size() > 0 && q[0].issue == edges) begin
        m_e = q.pop_front();
        m_beat = (m_e.be != 2'b00);
        total++;
        if (jcr_wen !== m_e.be) begin
          bad++; $display("FAIL beat_wen edge=%0d got=%b exp=%b", edges, jcr_wen, m_e.be);
        end
        if (m_e.be != 2'b00) begin
          total++;
          if ({jcr_tid, jcr_addr} !== {m_e.tid, m_e.addr}) begin
            bad++; $display("FAIL beat_addr edge=%0d got=%h exp=%h", edges, {jcr_tid, jcr_addr}, {m_e.tid, m_e.addr});
          end
        end
        if (m_e.be[0]) begin
          total++;
          if (jcr_dataL !== m_e.dl) begin
            bad++; $display("FAIL beat_dataL edge=%0d got=%h exp=%h", edges, jcr_dataL, m_e.dl);
          end
        end
        if (m_e.be[1]) begin
          total++;
          if (jcr_dataH !== m_e.dh) begin
            bad++; $display("FAIL beat_dataH edge=%0d got=%h exp=%h", edges, jcr_dataH, m_e.dh);
          end
        end
      end else begin
        total++;
        if (jcr_wen !== 2'b00) begin
          bad++; $display("FAIL idle_wen edge=%0d got=%b exp=00", edges, jcr_wen);
        end
      end
      if (jcr_wen != 2'b00) beats_seen++;
      total++;
      if (o_level !== LW'(q.size())) begin
        bad++; $display("FAIL level edge=%0d got=%0d exp=%0d", edges, o_level, q.size());
      end
      total++;
      if (o_busy !== ((q.size() != 0) || m_beat)) begin
        bad++; $display("FAIL busy edge=%0d got=%b exp=%b", edges, o_busy, (q.size() != 0) || m_beat);
      end
      total++;
      if (req_rdy !== (q.size() < DEPTH)) begin
        bad++; $display("FAIL rdy edge=%0d got=%b exp=%b", edges, req_rdy, q.size() < DEPTH);
      end
      if (req_stb && req_rdy) begin
        m_iss = (edges + 2 > last_issue + 1) ? edges + 2 : last_issue + 1;
        q.push_back('{issue: m_iss, tid: req_tid, addr: req_addr, be: req_be, dl: req_dataL, dh: req_dataH});
        last_issue = m_iss;
      end
    end
  end

  // Drive one request (called at posedge+1) and hold it until accepted
  task automatic send(input logic tid, input logic [3:0] addr, input logic [1:0] be,
                      input logic [31:0] dl, input logic [31:0] dh);
    req_stb = 1'b1; req_tid = tid; req_addr = addr; req_be = be; req_dataL = dl; req_dataH = dh;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        @(posedge clk); #1;
        req_stb = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    total++; bad++;
    $display("FAIL send_timeout got=rdy_low exp=accept");
    req_stb = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = !o_busy;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL idle_timeout got=busy exp=idle"); end
    @(posedge clk); #1;
  endtask

  task automatic wait_init();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = o_init_done;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL init_timeout got=0 exp=1"); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({jcr_wen, jcr_tid, jcr_addr, jcr_dataL, jcr_dataH} !== '0) begin
      bad++; $display("FAIL reset_bus got=%b/%h/%h/%h exp=0", jcr_wen, {jcr_tid, jcr_addr}, jcr_dataL, jcr_dataH);
    end
    total++;
    if ({req_rdy, o_busy, o_level} !== '0) begin
      bad++; $display("FAIL reset_status got=rdy%b busy%b lvl%0d exp=0", req_rdy, o_busy, o_level);
    end
    total++;
    if (o_init_done !== !INIT_EN) begin
      bad++; $display("FAIL reset_init_done got=%b exp=%b", o_init_done, !INIT_EN);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (req_rdy !== !INIT_EN) begin
      bad++; $display("FAIL post_reset_rdy got=%b exp=%b", req_rdy, !INIT_EN);
    end
  endtask

`ifdef ECO32_JCR_INIT_EN
  // Expects rst released at the preceding negedge
  task automatic test_sweep();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      total++;
      if (jcr_wen !== 2'b11 || {jcr_tid, jcr_addr} !== 5'(k) || jcr_dataL !== INIT_DL || jcr_dataH !== INIT_DH) begin
        bad++; $display("FAIL sweep_beat k=%0d got=%b/%0d/%h/%h", k, jcr_wen, {jcr_tid, jcr_addr}, jcr_dataL, jcr_dataH);
      end
      total++;
      if (o_init_done !== 1'b0 || req_rdy !== 1'b0) begin
        bad++; $display("FAIL sweep_gate k=%0d got=done%b rdy%b exp=00", k, o_init_done, req_rdy);
      end
    end
    @(negedge clk);
    total++;
    if (jcr_wen !== 2'b00 || o_init_done !== 1'b1 || req_rdy !== 1'b1) begin
      bad++; $display("FAIL sweep_end got=wen%b done%b rdy%b exp=00/1/1", jcr_wen, o_init_done, req_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_sweep();
    mon_en = 1'b0;
    rst = 1'b1; #3;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k <= 12; k++) @(negedge clk);
    total++;
    if (jcr_wen !== 2'b11 || {jcr_tid, jcr_addr} !== 5'd12) begin
      bad++; $display("FAIL midsweep_pos got=%b/%0d exp=11/12", jcr_wen, {jcr_tid, jcr_addr});
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({jcr_wen, jcr_tid, jcr_addr, jcr_dataL, jcr_dataH, o_init_done, o_level} !== '0) begin
      bad++; $display("FAIL midsweep_reset got=%b/%0d/%b/%0d exp=0", jcr_wen, {jcr_tid, jcr_addr}, o_init_done, o_level);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++;
    if (jcr_wen !== 2'b11 || {jcr_tid, jcr_addr} !== 5'd0) begin
      bad++; $display("FAIL midsweep_restart got=%b/%0d exp=11/0", jcr_wen, {jcr_tid, jcr_addr});
    end
    wait_init();
    mon_en = 1'b1;
  endtask
`endif

  task automatic test_single();
    wait_idle();
    send(1'b1, 4'd5, 2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge clk);
    total++;
    if (jcr_wen !== 2'b00 || o_level !== LW'(1)) begin
      bad++; $display("FAIL single_early got=wen%b lvl%0d exp=00/1", jcr_wen, o_level);
    end
    @(negedge clk);
    total++;
    if (jcr_wen !== 2'b01 || jcr_tid !== 1'b1 || jcr_addr !== 4'd5 || jcr_dataL !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL single_beat got=%b/%b/%0d/%h exp=01/1/5/deadbeef", jcr_wen, jcr_tid, jcr_addr, jcr_dataL);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int unsigned b0;
    wait_idle();
    b0 = beats_seen;
    for (int i = 0; i < 6; i++)
      send(1'(i), 4'(i + 2), 2'b11, 32'h1000 + 32'(i), 32'hF000 - 32'(i));
    wait_idle();
    total++;
    if (beats_seen - b0 !== 6) begin
      bad++; $display("FAIL burst_count got=%0d exp=6", beats_seen - b0);
    end
    total++;
    if (o_level !== '0) begin
      bad++; $display("FAIL burst_level got=%0d exp=0", o_level);
    end
  endtask

  task automatic test_same_entry();
    wait_idle();
    send(1'b0, 4'd3, 2'b10, 32'h0, 32'h1);
    send(1'b0, 4'd3, 2'b11, 32'h2, 32'h3);
    @(negedge clk);
    total++;
    if (jcr_wen !== 2'b10 || jcr_addr !== 4'd3 || jcr_dataH !== 32'h1) begin
      bad++; $display("FAIL same_first got=%b/%0d/%h exp=10/3/1", jcr_wen, jcr_addr, jcr_dataH);
    end
    @(negedge clk);
    total++;
    if (jcr_wen !== 2'b11 || jcr_addr !== 4'd3 || jcr_dataL !== 32'h2 || jcr_dataH !== 32'h3) begin
      bad++; $display("FAIL same_second got=%b/%0d/%h/%h exp=11/3/2/3", jcr_wen, jcr_addr, jcr_dataL, jcr_dataH);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_be_zero();
    logic [4:0]  a0;
    logic [31:0] l0;
    wait_idle();
    a0 = {jcr_tid, jcr_addr};
    l0 = jcr_dataL;
    send(1'b0, 4'd7, 2'b00, 32'hCAFE_0000, 32'hCAFE_1111);
    @(negedge clk);
    total++;
    if (jcr_wen !== 2'b00 || o_busy !== 1'b1) begin
      bad++; $display("FAIL be0_queued got=wen%b busy%b exp=00/1", jcr_wen, o_busy);
    end
    @(negedge clk);
    total++;
    if (jcr_wen !== 2'b00 || o_busy !== 1'b0 || {jcr_tid, jcr_addr} !== a0 || jcr_dataL !== l0) begin
      bad++; $display("FAIL be0_slot got=%b/%b/%0d/%h exp=00/0/%0d/%h", jcr_wen, o_busy, {jcr_tid, jcr_addr}, jcr_dataL, a0, l0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_stb   = ($urandom_range(0, 3) != 0);
      req_tid   = 1'($urandom);
      req_addr  = 4'($urandom);
      req_be    = 2'($urandom);
      req_dataL = $urandom;
      req_dataH = $urandom;
      @(posedge clk); #1;
    end
    req_stb = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid_burst();
    wait_idle();
    mon_en = 1'b0;
    send(1'b1, 4'd9, 2'b11, 32'h1111_1111, 32'h2222_2222);
    send(1'b0, 4'd10, 2'b11, 32'h3333_3333, 32'h4444_4444);
    total++;
    if (jcr_wen !== 2'b11 || o_level !== LW'(1)) begin
      bad++; $display("FAIL midburst_pre got=wen%b lvl%0d exp=11/1", jcr_wen, o_level);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({jcr_wen, jcr_tid, jcr_addr, jcr_dataL, jcr_dataH, o_level, o_busy, req_rdy} !== '0) begin
      bad++; $display("FAIL midburst_reset got=%b/%0d/%h/%0d/%b/%b exp=0", jcr_wen, {jcr_tid, jcr_addr}, jcr_dataL, o_level, o_busy, req_rdy);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++;
    if (INIT_EN ? (jcr_wen !== 2'b11 || {jcr_tid, jcr_addr} !== 5'd0) : (jcr_wen !== 2'b00 || o_level !== '0)) begin
      bad++; $display("FAIL midburst_after got=wen%b addr%0d lvl%0d", jcr_wen, {jcr_tid, jcr_addr}, o_level);
    end
    wait_init();
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
`ifdef ECO32_JCR_INIT_EN
    test_sweep();
`else
    @(posedge clk); #1;
`endif
    mon_en = 1'b1;
    test_single();
    test_back_to_back();
    test_same_entry();
    test_be_zero();
    test_random();
    test_reset_mid_burst();
`ifdef ECO32_JCR_INIT_EN
    test_reset_mid_sweep();
`endif
    test_single();
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
